// File: rtl/vs_store_seq_pkg.sv
// rtl/vs_store_seq_pkg.sv - shared constants and state encodings for the vector store sequencer
//
// Purpose: state encodings, VS-format opcode and default vector geometry shared
//          by the store sequencer and any future vector load sequencer.
// Ports:   none (package).
package vs_store_seq_pkg;

    localparam int VSQ_VLMAX_DEF = 8;
    localparam int VSQ_ELEN_DEF  = 32;

    // Major opcode of the VS store format as decoded in ID.
    localparam logic [6:0] VS_FORMAT = 7'b0100111;

    typedef enum logic [1:0] {
        VSQ_IDLE = 2'd0,
        VSQ_RUN  = 2'd1,
        VSQ_DONE = 2'd2
    } vsq_state_t;

endpackage

// File: rtl/vs_addr_gen.sv
// rtl/vs_addr_gen.sv - element address generator with latched stride
//
// Purpose: holds the current element byte address and the per-element step.
//          load captures base and step; advance adds step to the address,
//          wrapping modulo 2^XLEN (two's complement, so negative steps descend).
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   load          capture base/step_in (wins over advance)
//   advance       addr <= addr + step
//   base          start byte address
//   step_in       byte step to latch
//   addr          current byte address
module vs_addr_gen #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            advance,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] step_in,
    output logic [XLEN-1:0] addr
);

    logic [XLEN-1:0] step_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr   <= '0;
            step_q <= '0;
        end else if (load) begin
            addr   <= base;
            step_q <= step_in;
        end else if (advance) begin
            addr   <= addr + step_q;
        end
    end

endmodule

// File: rtl/vs_store_seq.sv
// rtl/vs_store_seq.sv - multi-cycle vector store sequencer for the EX/MEM stage
//
// Purpose: accepts a VS store, reads the source vector one element per cycle
//          and issues one memory write per element, stalling the pipeline
//          until all vl elements are written, then pulses done.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   start         VS store present in EX (held while stall is high)
//   base_addr     byte address of element 0
//   strided       0 = unit stride (ELEN/8), 1 = use stride
//   stride        signed byte stride
//   vl            element count, clamped to VLMAX
//   vrd_idx       vector register read index
//   vrd_data      element data for vrd_idx (combinational)
//   mem_wr_en     memory write request
//   mem_addr      write byte address
//   mem_wdata     write data
//   mem_ready     memory accepts the request this cycle
//   stall         freeze IF/ID/EX
//   done          one-cycle completion pulse
module vs_store_seq
    import vs_store_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ELEN  = VSQ_ELEN_DEF,
    parameter int VLMAX = VSQ_VLMAX_DEF,
    parameter int VL_W  = $clog2(VLMAX + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] base_addr,
    input  logic            strided,
    input  logic [XLEN-1:0] stride,
    input  logic [VL_W-1:0] vl,
    output logic [VL_W-1:0] vrd_idx,
    input  logic [ELEN-1:0] vrd_data,
    output logic            mem_wr_en,
    output logic [XLEN-1:0] mem_addr,
    output logic [ELEN-1:0] mem_wdata,
    input  logic            mem_ready,
    output logic            stall,
    output logic            done
);

    vsq_state_t      state;
    vsq_state_t      state_nx;
    logic [VL_W-1:0] cnt;
    logic [VL_W-1:0] vl_lat;
    logic [VL_W-1:0] vl_clamped;
    logic [XLEN-1:0] step_sel;
    logic            accept;
    logic            advance;

    assign vl_clamped = (vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : vl;
    assign step_sel   = strided ? stride : XLEN'(ELEN / 8);

    // Outputs are decoded from state, address and counter registers only, so
    // an asynchronous reset drops them without waiting for a clock edge.
    assign vrd_idx   = cnt;
    assign mem_wdata = vrd_data;

    vs_addr_gen #(
        .XLEN (XLEN)
    ) u_addr_gen (
        .clock   (clock),
        .reset   (reset),
        .load    (accept),
        .advance (advance),
        .base    (base_addr),
        .step_in (step_sel),
        .addr    (mem_addr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= VSQ_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            vl_lat <= '0;
        end else if (accept) begin
            cnt    <= '0;
            vl_lat <= vl_clamped;
        end else if (advance) begin
            cnt    <= cnt + VL_W'(1);
        end
    end

    always_comb begin
        state_nx  = state;
        stall     = 1'b0;
        mem_wr_en = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        advance   = 1'b0;
        case (state)
            VSQ_IDLE: begin
                // Gated by reset so stall reads 0 while reset is held.
                stall = start & ~reset;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (vl_clamped != '0) ? VSQ_RUN : VSQ_DONE;
                end
            end
            VSQ_RUN: begin
                stall     = 1'b1;
                mem_wr_en = 1'b1;
                if (mem_ready) begin
                    advance = 1'b1;
                    if (cnt == vl_lat - VL_W'(1)) begin
                        state_nx = VSQ_DONE;
                    end
                end
            end
            VSQ_DONE: begin
                // start is still high for the finished instruction here; ignore it.
                done     = 1'b1;
                state_nx = VSQ_IDLE;
            end
            default: begin
                state_nx = VSQ_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vs_store_seq.sv
// tb/tb_vs_store_seq.sv - self-checking bench for vs_store_seq
module tb_vs_store_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        strided = 1'b0;
    logic [31:0] stride = '0;
    logic [3:0]  vl = '0;
    logic [3:0]  vrd_idx;
    logic [31:0] vrd_data;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b1;
    logic        stall;
    logic        done;

    logic [31:0] vreg [0:15];
    int          n_cmp = 0;
    int          n_bad = 0;

    assign vrd_data = vreg[vrd_idx];

    always #5 clock = ~clock;

    vs_store_seq dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .strided   (strided),
        .stride    (stride),
        .vl        (vl),
        .vrd_idx   (vrd_idx),
        .vrd_data  (vrd_data),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .stall     (stall),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_vreg(input bit rnd);
        for (int i = 0; i < 16; i++) begin
            vreg[i] = rnd ? $urandom : 32'hA0 + 32'(i);
        end
    endtask

    // One idle cycle with start low: nothing may be requested or signalled.
    task automatic idle_cycle();
        start = 1'b0;
        #1;
        check_eq("idle_stall", {63'd0, stall}, 64'd0);
        check_eq("idle_wr", {63'd0, mem_wr_en}, 64'd0);
        check_eq("idle_done", {63'd0, done}, 64'd0);
        tick();
    endtask

    // Issues one store from IDLE and checks every cycle until the done pulse.
    // ready_pct < 0 selects the fixed pattern "ready low for the first 3 RUN cycles".
    // Returns one cycle after the done pulse with start still high, so the
    // caller either calls idle_cycle() or issues a back-to-back store.
    task automatic run_store(input logic [31:0] b, input logic s, input logic [31:0] st,
                             input int v, input int ready_pct);
        int          ve;
        logic [31:0] step;
        int          k;
        int          cyc;
        int          waits;
        bit          fin;
        bit          pend;
        logic [31:0] p_addr;
        logic [31:0] p_data;
        logic [3:0]  p_idx;
        logic [31:0] e_addr;
        ve    = (v > 8) ? 8 : v;
        step  = s ? st : 32'd4;
        k     = 0;
        cyc   = 0;
        waits = 0;
        fin   = 0;
        pend  = 0;
        p_addr = '0;
        p_data = '0;
        p_idx  = '0;
        base_addr = b;
        strided   = s;
        stride    = st;
        vl        = 4'(v);
        start     = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_eq("acc_stall", {63'd0, stall}, 64'd1);
        check_eq("acc_wr", {63'd0, mem_wr_en}, 64'd0);
        check_eq("acc_done", {63'd0, done}, 64'd0);
        tick();
        while (!fin && cyc < 200) begin
            if (ready_pct < 0) mem_ready = (cyc >= 3);
            else               mem_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (k < ve) begin
                e_addr = b + 32'(k) * step;
                check_eq("run_stall", {63'd0, stall}, 64'd1);
                check_eq("run_wr", {63'd0, mem_wr_en}, 64'd1);
                check_eq("run_done", {63'd0, done}, 64'd0);
                check_eq("run_addr", {32'd0, mem_addr}, {32'd0, e_addr});
                check_eq("run_data", {32'd0, mem_wdata}, {32'd0, vreg[k]});
                check_eq("run_idx", {60'd0, vrd_idx}, 64'(k));
                if (pend) begin
                    check_eq("hold_addr", {32'd0, mem_addr}, {32'd0, p_addr});
                    check_eq("hold_data", {32'd0, mem_wdata}, {32'd0, p_data});
                    check_eq("hold_idx", {60'd0, vrd_idx}, {60'd0, p_idx});
                end
                pend   = !mem_ready;
                p_addr = mem_addr;
                p_data = mem_wdata;
                p_idx  = vrd_idx;
                if (mem_ready) k++;
                else           waits++;
            end else begin
                check_eq("done_pulse", {63'd0, done}, 64'd1);
                check_eq("done_stall", {63'd0, stall}, 64'd0);
                check_eq("done_wr", {63'd0, mem_wr_en}, 64'd0);
                check_eq("latency", 64'(cyc + 2), 64'(ve + 2 + waits));
                check_eq("writes", 64'(k), 64'(ve));
                fin = 1;
            end
            tick();
            cyc++;
        end
        if (!fin) check_eq("timeout", 64'd0, 64'd1);
    endtask

    task automatic reset_mid_run();
        fill_vreg(1'b0);
        base_addr = 32'h200;
        strided   = 1'b0;
        vl        = 4'd4;
        start     = 1'b1;
        mem_ready = 1'b1;
        tick();                 // acceptance edge
        tick();                 // element 0 accepted
        tick();                 // element 1 accepted, now presenting element 2
        check_eq("pre_rst_idx", {60'd0, vrd_idx}, 64'd2);
        check_eq("pre_rst_addr", {32'd0, mem_addr}, 64'h208);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_wr", {63'd0, mem_wr_en}, 64'd0);
        check_eq("rst_stall", {63'd0, stall}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_idx", {60'd0, vrd_idx}, 64'd0);
        check_eq("rst_addr", {32'd0, mem_addr}, 64'd0);
        start = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq("post_rst_done", {63'd0, done}, 64'd0);
            check_eq("post_rst_wr", {63'd0, mem_wr_en}, 64'd0);
            tick();
        end
    endtask

    initial begin
        fill_vreg(1'b0);
        #3;
        check_eq("reset_wr", {63'd0, mem_wr_en}, 64'd0);
        check_eq("reset_stall", {63'd0, stall}, 64'd0);
        check_eq("reset_done", {63'd0, done}, 64'd0);
        check_eq("reset_idx", {60'd0, vrd_idx}, 64'd0);
        check_eq("reset_addr", {32'd0, mem_addr}, 64'd0);
        tick();
        reset = 1'b0;
        tick();

        run_store(32'h100, 1'b0, 32'd0, 4, 100);
        idle_cycle();
        run_store(32'h40, 1'b1, -32'sd8, 3, 100);
        idle_cycle();
        run_store(32'h300, 1'b0, 32'd0, 2, -1);
        idle_cycle();
        run_store(32'h500, 1'b0, 32'd0, 0, 100);
        idle_cycle();
        run_store(32'h600, 1'b0, 32'd0, 2, 100);
        run_store(32'h700, 1'b0, 32'd0, 1, 100);
        idle_cycle();
        run_store(32'hFFFF_FFF8, 1'b0, 32'd0, 12, 100);
        idle_cycle();

        reset_mid_run();
        run_store(32'h900, 1'b0, 32'd0, 4, 100);
        idle_cycle();

        for (int t = 0; t < 40; t++) begin
            int          v;
            int          pct;
            logic [31:0] st;
            fill_vreg(1'b1);
            v   = $urandom_range(12);
            pct = ($urandom_range(2) == 0) ? 100 : 30 + $urandom_range(60);
            st  = ($urandom_range(1) == 0) ? 32'($signed($urandom_range(64)) - 32) : $urandom;
            run_store($urandom, 1'($urandom_range(1)), st, v, pct);
            if ($urandom_range(1) == 0) idle_cycle();
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
